// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the imem fetch handshake, hands the
// instruction to the EXU, then emits a one-cycle PC update with its source select.
module fetch_seq_ctrl #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      TIMEOUT  = 255,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  output logic             imem_resp_ready,
  input  logic [31:0]      imem_resp_data,
  input  logic             imem_resp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             exu_done,
  input  logic             exu_trap,
  input  logic             exu_mret,
  output logic             pc_update,
  output logic [1:0]       pc_sel,
  output logic             fetch_fault,
  output logic [31:0]      retired
);

  localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    SEL_ADDER  = 2'b00;
  localparam logic [1:0]    SEL_MTVEC  = 2'b01;
  localparam logic [1:0]    SEL_MEPC   = 2'b11;

  typedef enum logic [2:0] {BOOT, REQ, WAIT_RESP, ISSUE, EXEC, UPDATE} state_t;

  state_t           state_reg, state_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic [31:0]      inst_reg, inst_next;
  logic [WIDTH-1:0] inst_pc_reg, inst_pc_next;
  logic [1:0]       pc_sel_reg, pc_sel_next;
  logic             fault_reg, fault_next;
  logic [31:0]      retired_reg, retired_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= BOOT;
      timer_reg   <= '0;
      inst_reg    <= 32'h0;
      inst_pc_reg <= RESET_PC;
      pc_sel_reg  <= SEL_ADDER;
      fault_reg   <= 1'b0;
      retired_reg <= 32'h0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
      pc_sel_reg  <= pc_sel_next;
      fault_reg   <= fault_next;
      retired_reg <= retired_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    pc_sel_next     = pc_sel_reg;
    fault_next      = fault_reg;
    retired_next    = retired_reg;
    imem_req_valid  = 1'b0;
    imem_resp_ready = 1'b0;
    inst_valid      = 1'b0;
    pc_update       = 1'b0;
    fetch_fault     = 1'b0;
    case (state_reg)
      BOOT: state_next = REQ;
      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          timer_next = '0;
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        imem_resp_ready = 1'b1;
        timer_next      = timer_reg + TW'(1);
        // A response in the final timer cycle still beats the timeout.
        if (imem_resp_valid && !imem_resp_err) begin
          inst_next    = imem_resp_data;
          inst_pc_next = pc;
          state_next   = ISSUE;
        end else if (imem_resp_valid || timer_reg == TIMER_LAST) begin
          pc_sel_next = SEL_MTVEC;
          fault_next  = 1'b1;
          state_next  = UPDATE;
        end
      end
      ISSUE: begin
        inst_valid = 1'b1;
        if (inst_ready) state_next = EXEC;
      end
      EXEC: begin
        if (exu_done) begin
          pc_sel_next = exu_trap ? SEL_MTVEC : (exu_mret ? SEL_MEPC : SEL_ADDER);
          state_next  = UPDATE;
        end
      end
      UPDATE: begin
        pc_update   = 1'b1;
        fetch_fault = fault_reg;
        fault_next  = 1'b0;
        if (!fault_reg) retired_next = retired_reg + 32'd1;
        state_next  = REQ;
      end
      default: state_next = BOOT;
    endcase
  end

  assign imem_req_addr = pc;
  assign inst          = inst_reg;
  assign inst_pc       = inst_pc_reg;
  assign pc_sel        = pc_sel_reg;
  assign retired       = retired_reg;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Randomized self-checking bench for fetch_seq_ctrl; expectations come from a
// transaction-level model (fault rule, response-latency arithmetic, retire count).
module tb_fetch_seq_ctrl;

  localparam int          WIDTH    = 32;
  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_ready, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        exu_done, exu_trap, exu_mret;
  logic        pc_update, fetch_fault;
  logic [1:0]  pc_sel;
  logic [31:0] retired;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_retired = 32'h0;

  fetch_seq_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .exu_done(exu_done), .exu_trap(exu_trap), .exu_mret(exu_mret),
    .pc_update(pc_update), .pc_sel(pc_sel), .fetch_fault(fetch_fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // One complete instruction transaction, starting at a negedge before/at REQ.
  task automatic do_instr(input int req_stall, input int lat, input bit err,
                          input int iss_stall, input int exu_lat,
                          input bit trap, input bit mret, input string tag);
    logic [31:0] data;
    logic [31:0] pc0;
    logic [1:0]  sel_exp;
    bit          fault;
    int          k, k_exp, cnt;
    data    = $urandom;
    pc0     = pc;
    fault   = err || (lat > TIMEOUT);
    k_exp   = (lat > TIMEOUT) ? TIMEOUT + 1 : lat + 1;
    sel_exp = fault ? 2'b01 : (trap ? 2'b01 : (mret ? 2'b11 : 2'b00));
    cnt = 0;
    while (imem_req_valid !== 1'b1 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (imem_req_valid !== 1'b1) begin
      $display("FAIL %s req_valid: got %b want 1", tag, imem_req_valid);
      n_err++;
      return;
    end
    n_vec++;
    if (imem_req_addr !== pc0) begin
      $display("FAIL %s req_addr: got %h want %h", tag, imem_req_addr, pc0);
      n_err++;
    end
    for (int i = 0; i < req_stall; i++) begin
      imem_req_ready = 1'b0;
      @(negedge clk);
      n_vec++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== pc0) begin
        $display("FAIL %s req_stall: got valid=%b addr=%h want valid=1 addr=%h",
                 tag, imem_req_valid, imem_req_addr, pc0);
        n_err++;
      end
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    k = 1;
    forever begin
      if (pc_update === 1'b1 || inst_valid === 1'b1 || k > TIMEOUT + 3) break;
      n_vec++;
      if (imem_resp_ready !== 1'b1) begin
        $display("FAIL %s resp_ready: got %b want 1 (cycle %0d)", tag, imem_resp_ready, k);
        n_err++;
      end
      imem_resp_valid = (k >= lat);
      imem_resp_data  = data;
      imem_resp_err   = err;
      exu_done        = 1'($urandom_range(0, 1));
      exu_trap        = 1'($urandom_range(0, 1));
      exu_mret        = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    exu_done = 1'b0; exu_trap = 1'b0; exu_mret = 1'b0;
    n_vec++;
    if (k != k_exp) begin
      $display("FAIL %s resp_latency: got %0d want %0d", tag, k, k_exp);
      n_err++;
    end
    if (fault) begin
      n_vec++;
      if (pc_update !== 1'b1 || pc_sel !== 2'b01 || fetch_fault !== 1'b1) begin
        $display("FAIL %s fault_update: got upd=%b sel=%b ff=%b want upd=1 sel=01 ff=1",
                 tag, pc_update, pc_sel, fetch_fault);
        n_err++;
      end
    end else begin
      n_vec++;
      if (inst_valid !== 1'b1 || inst !== data || inst_pc !== pc0) begin
        $display("FAIL %s issue: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                 tag, inst_valid, inst, inst_pc, data, pc0);
        n_err++;
      end
      for (int i = 0; i < iss_stall; i++) begin
        inst_ready = 1'b0;
        exu_done   = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_vec++;
        if (inst_valid !== 1'b1 || inst !== data || inst_pc !== pc0 || pc_update !== 1'b0) begin
          $display("FAIL %s issue_stall: got v=%b inst=%h pc=%h upd=%b want v=1 inst=%h pc=%h upd=0",
                   tag, inst_valid, inst, inst_pc, pc_update, data, pc0);
          n_err++;
        end
      end
      exu_done   = 1'b0;
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      for (int i = 0; i < exu_lat; i++) begin
        n_vec++;
        if (pc_update !== 1'b0 || inst_valid !== 1'b0) begin
          $display("FAIL %s exec_wait: got upd=%b v=%b want upd=0 v=0", tag, pc_update, inst_valid);
          n_err++;
        end
        @(negedge clk);
      end
      exu_done = 1'b1; exu_trap = trap; exu_mret = mret;
      @(negedge clk);
      exu_done = 1'b0; exu_trap = 1'b0; exu_mret = 1'b0;
      exp_retired = exp_retired + 32'd1;
      n_vec++;
      if (pc_update !== 1'b1 || pc_sel !== sel_exp || fetch_fault !== 1'b0) begin
        $display("FAIL %s update: got upd=%b sel=%b ff=%b want upd=1 sel=%b ff=0",
                 tag, pc_update, pc_sel, fetch_fault, sel_exp);
        n_err++;
      end
    end
    pc = $urandom & 32'hFFFF_FFFC;
    @(negedge clk);
    n_vec++;
    if (pc_update !== 1'b0 || fetch_fault !== 1'b0 || retired !== exp_retired || pc_sel !== sel_exp) begin
      $display("FAIL %s post_update: got upd=%b ff=%b ret=%0d sel=%b want upd=0 ff=0 ret=%0d sel=%b",
               tag, pc_update, fetch_fault, retired, pc_sel, exp_retired, sel_exp);
      n_err++;
    end
    $display("txn %s pc=%h lat=%0d err=%b fault=%b sel=%b retired=%0d",
             tag, pc0, lat, err, fault, sel_exp, retired);
  endtask

  task automatic test_reset();
    rst = 1'b0; pc = RESET_PC;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    imem_resp_err = 1'b0; inst_ready = 1'b0;
    exu_done = 1'b0; exu_trap = 1'b0; exu_mret = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({imem_req_valid, imem_resp_ready, inst_valid, pc_update, fetch_fault, pc_sel, inst, inst_pc, retired}
        !== {5'b0, 2'b00, 32'h0, RESET_PC, 32'h0}) begin
      $display("FAIL reset_values: got rv=%b rr=%b iv=%b upd=%b ff=%b sel=%b inst=%h ipc=%h ret=%0d",
               imem_req_valid, imem_resp_ready, inst_valid, pc_update, fetch_fault, pc_sel, inst, inst_pc, retired);
      n_err++;
    end
  endtask

  task automatic test_boot();
    rst = 1'b1;
    #1;
    n_vec++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL boot_idle: got req_valid=%b want 0", imem_req_valid);
      n_err++;
    end
    @(negedge clk);
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      $display("FAIL boot_req: got v=%b addr=%h want v=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
      n_err++;
    end
    imem_resp_data = 32'h0000_0013;
    do_instr(0, 1, 1'b0, 0, 0, 1'b0, 1'b0, "boot");
  endtask

  task automatic test_backpressure();
    do_instr(3, 2, 1'b0, 2, 2, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_fetch_error();
    do_instr(0, 1, 1'b1, 0, 0, 1'b0, 1'b0, "fetch_error");
    do_instr(0, TIMEOUT, 1'b0, 0, 0, 1'b0, 1'b0, "resp_at_last_cycle");
    do_instr(0, TIMEOUT, 1'b1, 0, 0, 1'b0, 1'b0, "err_at_last_cycle");
  endtask

  task automatic test_timeout();
    do_instr(1, TIMEOUT + 5, 1'b0, 0, 0, 1'b0, 1'b0, "timeout");
    imem_resp_valid = 1'b1;
    imem_req_ready  = 1'b0;
    @(negedge clk);
    n_vec++;
    if (imem_resp_ready !== 1'b0 || imem_req_valid !== 1'b1) begin
      $display("FAIL late_resp: got resp_ready=%b req_valid=%b want 0 1", imem_resp_ready, imem_req_valid);
      n_err++;
    end
    imem_resp_valid = 1'b0;
  endtask

  task automatic test_trap_priority();
    do_instr(0, 1, 1'b0, 0, 1, 1'b1, 1'b1, "trap_and_mret");
    do_instr(0, 1, 1'b0, 0, 1, 1'b0, 1'b1, "mret_only");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_instr($urandom_range(0, 3), $urandom_range(1, TIMEOUT + 2),
               ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_async_reset();
    n_vec++;
    if (imem_req_valid !== 1'b1) begin
      $display("FAIL arst_setup: got req_valid=%b want 1", imem_req_valid);
      n_err++;
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = $urandom;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    n_vec++;
    if (inst_valid !== 1'b0 || pc_update !== 1'b0) begin
      $display("FAIL arst_exec: got v=%b upd=%b want 0 0", inst_valid, pc_update);
      n_err++;
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({imem_req_valid, imem_resp_ready, inst_valid, pc_update, fetch_fault, pc_sel, inst, inst_pc, retired}
        !== {5'b0, 2'b00, 32'h0, RESET_PC, 32'h0}) begin
      $display("FAIL async_reset: got rv=%b rr=%b iv=%b upd=%b ff=%b sel=%b inst=%h ipc=%h ret=%0d",
               imem_req_valid, imem_resp_ready, inst_valid, pc_update, fetch_fault, pc_sel, inst, inst_pc, retired);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b1;
    pc  = RESET_PC;
    exp_retired = 32'h0;
    #1;
    n_vec++;
    if (imem_req_valid !== 1'b0) begin
      $display("FAIL arst_boot: got req_valid=%b want 0", imem_req_valid);
      n_err++;
    end
    @(negedge clk);
    n_vec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      $display("FAIL arst_refetch: got v=%b addr=%h want v=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
      n_err++;
    end
    do_instr(0, 1, 1'b0, 0, 0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_fetch_error();
    test_timeout();
    test_trap_priority();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
